// File: rtl/psram_cmd_pkg.sv
// Shared types and constants for the PSRAM command sequencer.
package psram_cmd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWdata,
      StIssue,
      StWait,
      StTxHi,
      StTxLo
   } seq_state_t;

   localparam logic [7:0] OP_READ  = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h01;

   localparam int unsigned ADDR_BYTES = 3;
   localparam int unsigned DATA_BYTES = 2;

endpackage

// File: rtl/psram_cmd_seq.sv
// UART byte stream to single-word PSRAM read/write sequencer.
// Optional inter-byte timeout on partial commands: define PSRAM_SEQ_TIMEOUT_EN.
module psram_cmd_seq
   import psram_cmd_pkg::*;
#(
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned TIMEOUT_US = 1000
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              tick_1us,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err
);

   seq_state_t        state_q, state_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [7:0]        rdata_lo_q, rdata_lo_d;
   logic              err_q, err_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;

`ifdef PSRAM_SEQ_TIMEOUT_EN
   localparam int unsigned GapW = $clog2(TIMEOUT_US + 1);
   localparam logic [GapW-1:0] GapMax = GapW'(TIMEOUT_US);
   logic [GapW-1:0] gap_q, gap_d;
`else
   logic unused_tick;
   assign unused_tick = tick_1us;
`endif

   always_comb begin
      state_d     = state_q;
      mem_we_d    = mem_we_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_d       = cnt_q;
      tx_data_d   = tx_data_q;
      rdata_lo_d  = rdata_lo_q;
      err_d       = err_q;
      drop_cnt_d  = drop_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (rx_valid) begin
               if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                  mem_we_d = rx_data[0];
                  cnt_d    = 2'd0;
                  state_d  = StAddr;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StAddr: begin
            if (rx_valid) begin
               mem_addr_d = {mem_addr_q[ADDR_W-9:0], rx_data};
               if (cnt_q == 2'(ADDR_BYTES - 1)) begin
                  cnt_d   = 2'd0;
                  state_d = mem_we_q ? StWdata : StIssue;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         StWdata: begin
            if (rx_valid) begin
               mem_wdata_d = {mem_wdata_q[DATA_W-9:0], rx_data};
               if (cnt_q == 2'(DATA_BYTES - 1)) begin
                  cnt_d   = 2'd0;
                  state_d = StIssue;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         StIssue: begin
            mem_req_d = 1'b1;
            state_d   = StWait;
         end
         StWait: begin
            if (mem_ack && mem_req_q) begin
               mem_req_d = 1'b0;
               if (mem_we_q) begin
                  state_d = StIdle;
               end else begin
                  tx_data_d  = mem_rdata[DATA_W-1:DATA_W-8];
                  rdata_lo_d = mem_rdata[7:0];
                  state_d    = StTxHi;
               end
            end
         end
         StTxHi: begin
            if (tx_ready) begin
               tx_data_d = rdata_lo_q;
               state_d   = StTxLo;
            end
         end
         StTxLo: begin
            if (tx_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Bytes arriving while a transaction is in flight are discarded.
      if (rx_valid && state_q inside {StIssue, StWait, StTxHi, StTxLo} &&
          drop_cnt_q != 8'hFF) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end

`ifdef PSRAM_SEQ_TIMEOUT_EN
      gap_d = '0;
      if (state_q == StAddr || state_q == StWdata) begin
         if (gap_q == GapMax) begin
            state_d = StIdle;
            err_d   = 1'b1;
            cnt_d   = 2'd0;
         end else if (rx_valid) begin
            gap_d = '0;
         end else if (tick_1us) begin
            gap_d = gap_q + 1'b1;
         end else begin
            gap_d = gap_q;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q     <= StIdle;
         mem_we_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cnt_q       <= 2'd0;
         tx_data_q   <= 8'h00;
         rdata_lo_q  <= 8'h00;
         err_q       <= 1'b0;
         drop_cnt_q  <= 8'h00;
`ifdef PSRAM_SEQ_TIMEOUT_EN
         gap_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cnt_q       <= cnt_d;
         tx_data_q   <= tx_data_d;
         rdata_lo_q  <= rdata_lo_d;
         err_q       <= err_d;
         drop_cnt_q  <= drop_cnt_d;
`ifdef PSRAM_SEQ_TIMEOUT_EN
         gap_q       <= gap_d;
`endif
      end
   end

   assign tx_valid  = (state_q == StTxHi) || (state_q == StTxLo);
   assign tx_data   = tx_data_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != StIdle);
   assign err       = err_q;

endmodule

// File: tb/tb_psram_cmd_seq.sv
// Self-checking bench: directed cases plus randomized command traffic against a memory model.
module tb_psram_cmd_seq;

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 10;

   logic          clk = 1'b0;
   logic          arst_n;
   logic          tick_1us;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_ready;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   logic          err;

   int   n_checks = 0;
   int   n_errs   = 0;
   logic err_exp  = 1'b0;
   int   drop_exp = 0;
   logic [15:0] mem_model [int];

   always #5 clk = ~clk;

   psram_cmd_seq #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .TIMEOUT_US(TO)
   ) dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .tick_1us (tick_1us),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .err      (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic we, input logic [23:0] a, input logic [15:0] d,
                           input bit rnd);
      send_byte(we ? 8'h01 : 8'h00, rnd ? $urandom_range(0, 2) : 0);
      for (int i = 2; i >= 0; i--) send_byte(a[i*8 +: 8], rnd ? $urandom_range(0, 2) : 0);
      if (we) begin
         send_byte(d[15:8], rnd ? $urandom_range(0, 2) : 0);
         send_byte(d[7:0], rnd ? $urandom_range(0, 2) : 0);
      end
   endtask

   // Acts as the PSRAM controller and UART transmitter for one transaction.
   task automatic serve(input logic we, input logic [23:0] a, input logic [15:0] d,
                        input int lat, input int ready_pct, input int hold, input string tag);
      int w;
      int idx;
      int cyc;
      logic [15:0] val;
      logic [7:0]  exp_b [2];
      w = 0;
      while (!mem_req && w < 10) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_req"}, mem_req, 1'b1);
      check({tag, "_req_lat"}, w, 1);
      check({tag, "_we"}, mem_we, we);
      check({tag, "_addr"}, mem_addr, a);
      if (we) check({tag, "_wdata"}, mem_wdata, d);
      for (int i = 0; i < lat; i++) begin
         rx_valid = ($urandom_range(0, 3) == 0);
         rx_data  = 8'($urandom);
         if (rx_valid) drop_exp = sat_inc(drop_exp);
         @(negedge clk);
         rx_valid = 1'b0;
         check({tag, "_req_hold"}, mem_req, 1'b1);
         check({tag, "_addr_hold"}, mem_addr, a);
      end
      if (we) begin
         mem_model[int'(a)] = d;
         val = 16'($urandom);
      end else begin
         if (!mem_model.exists(int'(a))) mem_model[int'(a)] = 16'($urandom);
         val = mem_model[int'(a)];
      end
      mem_ack   = 1'b1;
      mem_rdata = val;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      check({tag, "_req_drop"}, mem_req, 1'b0);
      if (we) begin
         check({tag, "_wr_busy"}, busy, 1'b0);
         check({tag, "_wr_notx"}, tx_valid, 1'b0);
      end else begin
         exp_b[0] = val[15:8];
         exp_b[1] = val[7:0];
         idx = 0;
         cyc = 0;
         while (idx < 2 && cyc < 400) begin
            check({tag, "_tx_valid"}, tx_valid, 1'b1);
            check({tag, "_tx_data"}, tx_data, exp_b[idx]);
            tx_ready = (cyc >= hold) && ($urandom_range(0, 99) < ready_pct);
            rx_valid = ($urandom_range(0, 4) == 0);
            rx_data  = 8'($urandom);
            if (rx_valid) drop_exp = sat_inc(drop_exp);
            if (tx_ready) idx++;
            @(negedge clk);
            cyc++;
         end
         tx_ready = 1'b0;
         rx_valid = 1'b0;
         check({tag, "_tx_done"}, idx, 2);
         check({tag, "_rd_busy"}, busy, 1'b0);
         check({tag, "_rd_txoff"}, tx_valid, 1'b0);
      end
      check({tag, "_err"}, err, err_exp);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_req"}, mem_req, 1'b0);
      check({tag, "_we"}, mem_we, 1'b0);
      check({tag, "_txv"}, tx_valid, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_addr"}, mem_addr, 24'h0);
      check({tag, "_wdata"}, mem_wdata, 16'h0);
      check({tag, "_txd"}, tx_data, 8'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("rst");
      arst_n   = 1'b1;
      err_exp  = 1'b0;
      drop_exp = 0;
   endtask

   initial begin
      int kind;
      int w;
      logic [23:0] a;
      logic [15:0] d;
      logic [7:0]  b;
      arst_n    = 1'b0;
      tick_1us  = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      tx_ready  = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0;
      repeat (2) @(negedge clk);
      check_reset_vals("init");
      arst_n = 1'b1;

      mem_model[int'(24'h223344)] = 16'hBEEF;
      send_cmd(1'b0, 24'h223344, 16'h0, 1'b0);
      serve(1'b0, 24'h223344, 16'h0, 2, 100, 0, "rd");

      send_cmd(1'b1, 24'h020304, 16'h0707, 1'b0);
      serve(1'b1, 24'h020304, 16'h0707, 0, 100, 0, "wr");

      send_byte(8'h5A, 0);
      err_exp = 1'b1;
      check("bad_err", err, 1'b1);
      check("bad_idle", busy, 1'b0);
      send_cmd(1'b0, 24'h020304, 16'h0, 1'b0);
      serve(1'b0, 24'h020304, 16'h0, 1, 100, 0, "rd_after_bad");

      send_cmd(1'b0, 24'h223344, 16'h0, 1'b0);
      serve(1'b0, 24'h223344, 16'h0, 0, 100, 50, "bp");

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 7);
         a    = 24'hA00000 | 24'($urandom_range(0, 7));
         d    = 16'($urandom);
         if (kind == 0) begin
            b = 8'($urandom_range(2, 255));
            send_byte(b, $urandom_range(0, 2));
            err_exp = 1'b1;
            check("rnd_bad_err", err, 1'b1);
            check("rnd_bad_idle", busy, 1'b0);
         end else begin
            send_cmd(kind <= 3, a, d, 1'b1);
            serve(kind <= 3, a, d, $urandom_range(0, 4), $urandom_range(30, 100),
                  $urandom_range(0, 3), "rnd");
         end
      end
      check("drop_cnt", 32'(dut.drop_cnt_q), drop_exp);

      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h22, 0);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         tick_1us = 1'b1;
         @(negedge clk);
         tick_1us = 1'b0;
      end
      @(negedge clk);
`ifdef PSRAM_SEQ_TIMEOUT_EN
      err_exp = 1'b1;
      check("to_idle", busy, 1'b0);
      check("to_err", err, 1'b1);
`else
      check("to_wait_busy", busy, 1'b1);
      check("to_wait_err", err, 1'b0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      serve(1'b0, 24'h223344, 16'h0, 0, 100, 0, "to_resume");
`endif

      do_reset();
      send_cmd(1'b0, 24'h123456, 16'h0, 1'b0);
      w = 0;
      while (!mem_req && w < 10) begin
         @(negedge clk);
         w++;
      end
      check("wrst_req", mem_req, 1'b1);
      arst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("wrst");
      arst_n  = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("late_ack_busy", busy, 1'b0);
      check("late_ack_txv", tx_valid, 1'b0);
      check("late_ack_req", mem_req, 1'b0);

      send_cmd(1'b0, 24'h223344, 16'h0, 1'b0);
      serve(1'b0, 24'h223344, 16'h0, 1, 100, 0, "final");

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
